// File: rtl/ita_step_scheduler.sv
// ita_step_scheduler: walks heads x steps (Q,K,V,QK,AV,OW) x tiles. Each tile
// goes out as one command on a valid/ready channel. Outstanding tiles are
// credit-limited, and each step drains completely before the next one starts.
package ita_step_pkg;
  typedef enum logic [2:0] {
    StepIdle = 3'd0,
    StepQ    = 3'd1,
    StepK    = 3'd2,
    StepV    = 3'd3,
    StepQK   = 3'd4,
    StepAV   = 3'd5,
    StepOW   = 3'd6
  } step_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssue  = 2'd1,
    StDrain  = 2'd2,
    StFinish = 2'd3
  } state_e;
endpackage

// Handshake: a command transfers on a cycle where tile_valid_o && tile_ready_i.
// Once raised, valid stays high and step/tile/head stay stable until that
// transfer happens. tile_done_i is an unconditional one-cycle completion pulse.
module ita_step_scheduler
  import ita_step_pkg::*;
#(
  parameter int unsigned H              = 1,
  parameter int unsigned MaxOutstanding = 2,
  localparam int unsigned HeadW         = $clog2(H + 1),
  localparam int unsigned OutW          = $clog2(MaxOutstanding + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [31:0]      lin_tiles_i,
  input  logic [31:0]      attn_tiles_i,
  input  logic [HeadW-1:0] n_heads_i,
  output logic             tile_valid_o,
  input  logic             tile_ready_i,
  output step_e            step_o,
  output logic [31:0]      tile_idx_o,
  output logic [HeadW-1:0] head_idx_o,
  input  logic             tile_done_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  state_e           state_q, state_d;
  step_e            step_q, step_d;
  logic [31:0]      tile_q, tile_d;
  logic [31:0]      lin_q, lin_d;
  logic [31:0]      attn_q, attn_d;
  logic [HeadW-1:0] head_q, head_d;
  logic [HeadW-1:0] nh_q, nh_d;
  logic [OutW-1:0]  outst_q, outst_d;
  logic             err_q, err_d;

  logic [31:0]      step_count;
  logic             tile_valid;
  logic             hs;

  // Valid depends only on registered state, so ready/done never feed back into it.
  always_comb begin
    step_count = (step_q == StepQK || step_q == StepAV) ? attn_q : lin_q;
    tile_valid = (state_q == StIssue) && (tile_q < step_count) &&
                 (outst_q < OutW'(MaxOutstanding));
    hs         = tile_valid && tile_ready_i;
  end

  // Sequencer: config latch, tile/step/head walk, drain barrier, credit count.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    tile_d  = tile_q;
    lin_d   = lin_q;
    attn_d  = attn_q;
    head_d  = head_q;
    nh_d    = nh_q;
    outst_d = outst_q;
    err_d   = 1'b0;

    // Credits: issue adds one, completion removes one. A completion with
    // nothing in flight and no same-cycle issue is spurious and only flagged.
    if (hs && !tile_done_i) begin
      outst_d = outst_q + OutW'(1);
    end else if (!hs && tile_done_i) begin
      if (outst_q != '0) outst_d = outst_q - OutW'(1);
      else               err_d   = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          lin_d   = lin_tiles_i;
          attn_d  = attn_tiles_i;
          nh_d    = n_heads_i;
          head_d  = '0;
          step_d  = StepQ;
          tile_d  = '0;
          outst_d = '0;
          state_d = (n_heads_i == '0) ? StFinish : StIssue;
        end
      end
      StIssue: begin
        if (hs) begin
          tile_d = tile_q + 32'd1;
          if (tile_q + 32'd1 >= step_count) state_d = StDrain;
        end else if (tile_q >= step_count) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Barrier: the next step only starts once every tile of this one is back.
        if (outst_q == '0) begin
          tile_d = '0;
          if (step_q == StepOW) begin
            step_d = StepQ;
            if (head_q + HeadW'(1) == nh_q) begin
              head_d  = '0;
              state_d = StFinish;
            end else begin
              head_d  = head_q + HeadW'(1);
              state_d = StIssue;
            end
          end else begin
            step_d  = step_e'(step_q + 3'd1);
            state_d = StIssue;
          end
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset abandons any run and forgets in-flight tiles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      step_q  <= StepQ;
      tile_q  <= '0;
      lin_q   <= '0;
      attn_q  <= '0;
      head_q  <= '0;
      nh_q    <= '0;
      outst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      tile_q  <= tile_d;
      lin_q   <= lin_d;
      attn_q  <= attn_d;
      head_q  <= head_d;
      nh_q    <= nh_d;
      outst_q <= outst_d;
      err_q   <= err_d;
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    busy_o       = (state_q == StIssue) || (state_q == StDrain);
    done_o       = (state_q == StFinish);
    err_o        = err_q;
    tile_valid_o = tile_valid;
    step_o       = busy_o ? step_q : StepIdle;
    tile_idx_o   = tile_q;
    head_idx_o   = head_q;
  end

endmodule
